// File: rtl/rr_arbiter_hold.sv
// rr_arbiter_hold: N-way round-robin arbiter for one crossbar output port.
// The registered one-hot grant stays with its owner for as long as the owner
// keeps requesting. On release, the grant passes straight to the next requester
// in rotating order with no idle cycle in between.
// Optional hold timeout: define ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles.
module rr_arbiter_hold #(
  parameter int N        = 16,
  parameter int ID_W     = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    request,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            timeout_pulse
);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  localparam logic [N-1:0]    ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N - 1);

  state_t          r_state;
  logic [N-1:0]    r_grant;
  logic            r_grantValid;
  logic [ID_W-1:0] r_grantId;
  logic [ID_W-1:0] r_ptr;
  logic            r_timeout;

  logic            w_ownerReq;
  logic            w_forceRelease;
  logic            w_arbitrate;
  logic [N-1:0]    w_scanReq;
  logic            w_hit;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_nextPtr;

  // Empty on purpose: this block is only elaborated for an out-of-range parameter set.
  if ((ID_W != $clog2(N)) || (N < 2) || (MAX_HOLD < 1)) begin : g_illegalParams
  end

  assign w_ownerReq = request[r_grantId];

`ifdef ARB_TIMEOUT_EN
  localparam int              CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_holdCnt;

  assign w_forceRelease = (r_state == ST_OWNED) && w_ownerReq && (r_holdCnt == HOLD_LAST);

  // Count the cycles of the current ownership; restart on every new or renewed grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_holdCnt <= '0;
    end else if (w_arbitrate && (w_hit || w_forceRelease)) begin
      r_holdCnt <= '0;
    end else if (r_state == ST_OWNED) begin
      r_holdCnt <= r_holdCnt + 1'b1;
    end
  end
`else
  assign w_forceRelease = 1'b0;
`endif

  // An owner on timeout is removed from the scan, so any other requester is preferred
  assign w_scanReq   = w_forceRelease ? (request & ~r_grant) : request;
  assign w_arbitrate = (r_state == ST_IDLE) || !w_ownerReq || w_forceRelease;
  assign w_nextPtr   = (w_winner == LAST_ID) ? '0 : w_winner + 1'b1;

  // Find the first requester at or after ptr, wrapping through N-1 back to 0
  always_comb begin
    int idx;
    idx      = 0;
    w_hit    = 1'b0;
    w_winner = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!w_hit && w_scanReq[idx[ID_W-1:0]]) begin
        w_hit    = 1'b1;
        w_winner = idx[ID_W-1:0];
      end
    end
  end

  // Ownership FSM: hold while the owner requests, otherwise hand over or go idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_grantValid <= 1'b0;
      r_grantId    <= '0;
      r_ptr        <= '0;
      r_timeout    <= 1'b0;
    end else if (w_arbitrate) begin
      if (w_hit) begin
        r_state      <= ST_OWNED;
        r_grant      <= ONE_HOT_0 << w_winner;
        r_grantValid <= 1'b1;
        r_grantId    <= w_winner;
        r_ptr        <= w_nextPtr;
        r_timeout    <= w_forceRelease;
      end else if (w_forceRelease) begin
        // Sole requester on timeout keeps the grant; ptr already points past it
        r_timeout <= 1'b1;
      end else begin
        r_state      <= ST_IDLE;
        r_grant      <= '0;
        r_grantValid <= 1'b0;
        r_grantId    <= '0;
        r_timeout    <= 1'b0;
      end
    end else begin
      r_timeout <= 1'b0;
    end
  end

  assign grant         = r_grant;
  assign grant_valid   = r_grantValid;
  assign grant_id      = r_grantId;
  assign timeout_pulse = r_timeout;

endmodule
